tick_traffic_controller: RTL and testbench
==========================================

Name: tick_traffic_controller

Overview:
- Downstream consumer of the periodic one-cycle tick from the 3-state divider FSM (its q output).
- Moore FSM for a main/side street intersection; every phase duration is counted in ticks, not clocks.
- Main road rests green; a latched side-street request triggers one full side cycle.
- Lamp outputs drive the board LED decoder.

Parameters:
- GREEN_TICKS, 8, minimum main-green duration in ticks (>=1)
- YELLOW_TICKS, 2, yellow duration for either road (>=1)
- ALLRED_TICKS, 1, all-red clearance duration (>=1)
- SIDE_TICKS, 4, side-green duration (>=1)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous active-low reset (0 = reset)
- tick  in  1  one-cycle enable pulse from the upstream divider
- side_sensor  in  1  side-street car present, level, synchronous to clk
- main_light  out  2  main lamp code (RED/YELLOW/GREEN)
- side_light  out  2  side lamp code
- req_pending  out  1  latched side request (status)

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- States: MAIN_GREEN, MAIN_YELLOW, ALLRED_TO_SIDE, SIDE_GREEN, SIDE_YELLOW, ALLRED_TO_MAIN.
- Reset (reset=0) takes effect immediately, without waiting for clk:
  - state=MAIN_GREEN, timer=0, req_pending=0
  - main_light=GREEN, side_light=RED
- Timer and tick rules:
  - Timer width is $clog2(max duration parameter + 1).
  - Timer is cleared to 0 on every state change.
  - Timer changes only on edges where tick=1. tick=0 freezes the state and timer entirely.
- Timed states (every state except MAIN_GREEN), with duration D:
  - On a tick edge with timer==D-1, advance to the next state in the listed order; ALLRED_TO_MAIN wraps to MAIN_GREEN.
  - Otherwise increment timer.
- MAIN_GREEN:
  - On a tick edge with timer<GREEN_TICKS-1, increment timer.
  - On a tick edge with timer==GREEN_TICKS-1, saturate. Go to MAIN_YELLOW if req_pending=1, else stay.
  - A request arriving after the minimum has expired causes the transition on the next tick edge.
- Request latch:
  - req_pending is set on any clk edge with side_sensor=1, tick or not.
  - It is cleared on the edge that enters SIDE_GREEN.
  - side_sensor is ignored while in SIDE_GREEN and while entering it, so clear wins there.
  - Sampling resumes from SIDE_YELLOW onward, so a car arriving late queues the next cycle.
- Outputs are a pure decode of the state register (Moore, no combinational path from inputs):
  - MAIN_GREEN: main GREEN, side RED
  - MAIN_YELLOW: main YELLOW, side RED
  - ALLRED_TO_SIDE and ALLRED_TO_MAIN: both RED
  - SIDE_GREEN: main RED, side GREEN
  - SIDE_YELLOW: main RED, side YELLOW
- Safety invariant: never both lights non-RED at the same time.
- Unreachable state encodings go to MAIN_GREEN via the default branch.
- Latency: lights change on the same clk edge that samples the qualifying tick.

Decomposition:
- Package traffic_pkg:
  - light code typedef: RED=2'b00, YELLOW=2'b01, GREEN=2'b10
  - state enum typedef (logic [2:0])
- Optional sub-module phase_timer: tick-enabled up-counter with clear, terminal-count compare and saturate.
- The top level holds the state register, next-state logic, request latch and output decode.

Test Plan:
- Reset, side_sensor=0, 30 ticks (tick every 3 clks) -> main GREEN and side RED throughout; req_pending=0.
- side_sensor pulsed 1 clk before tick 2 -> main GREEN through the 8th tick edge, then:
  - YELLOW 2 ticks
  - all-red 1 tick
  - side GREEN 4 ticks
  - side YELLOW 2 ticks
  - all-red 1 tick
  - main GREEN again
  - req_pending drops on SIDE_GREEN entry.
- side_sensor pulsed at tick 20 (minimum expired) -> MAIN_YELLOW on the very next tick edge.
- tick held 0 for 50 clks with side_sensor=1 -> state and lights frozen; req_pending=1.
- reset driven 0 mid-SIDE_GREEN between clk edges -> main GREEN, side RED, req_pending=0 immediately.
- side_sensor held 1 continuously -> repeating cycle with main green exactly 8 ticks each time; invariant assertion never fails.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared lamp codes, controller states and sizing helper for the tick-driven
// traffic controller.
package traffic_pkg;

  typedef enum logic [1:0] {
    Red    = 2'b00,
    Yellow = 2'b01,
    Green  = 2'b10
  } light_e;

  typedef enum logic [2:0] {
    StMainGreen    = 3'd0,
    StMainYellow   = 3'd1,
    StAllredToSide = 3'd2,
    StSideGreen    = 3'd3,
    StSideYellow   = 3'd4,
    StAllredToMain = 3'd5
  } state_e;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Tick-enabled phase counter: clears on phase change, stops at the terminal
// value so the main-green minimum can saturate while waiting for a request.
module phase_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             clear,
  input  logic [WIDTH-1:0] term,
  output logic             done
);

  logic [WIDTH-1:0] count_q, count_d;

  assign done = (count_q == term);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (tick && !done) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/tick_traffic_controller.sv
// Main/side intersection controller; every phase is timed in upstream ticks.
// Main road rests green; a latched side request runs one full side cycle.
module tick_traffic_controller
  import traffic_pkg::*;
#(
  parameter int unsigned GREEN_TICKS  = 8,
  parameter int unsigned YELLOW_TICKS = 2,
  parameter int unsigned ALLRED_TICKS = 1,
  parameter int unsigned SIDE_TICKS   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       side_sensor,
  output logic [1:0] main_light,
  output logic [1:0] side_light,
  output logic       req_pending
);

  localparam int unsigned MaxTicks = max4(GREEN_TICKS, YELLOW_TICKS, ALLRED_TICKS, SIDE_TICKS);
  localparam int unsigned TimerW   = $clog2(MaxTicks + 1);

  state_e              state_q, state_d;
  logic                req_q, req_d;
  logic                done;
  logic                state_change;
  logic [TimerW-1:0]   term;

  always_comb begin
    case (state_q)
      StMainGreen:    term = TimerW'(GREEN_TICKS - 1);
      StMainYellow,
      StSideYellow:   term = TimerW'(YELLOW_TICKS - 1);
      StSideGreen:    term = TimerW'(SIDE_TICKS - 1);
      default:        term = TimerW'(ALLRED_TICKS - 1);
    endcase
  end

  phase_timer #(
    .WIDTH (TimerW)
  ) u_phase_timer (
    .clk   (clk),
    .reset (reset),
    .tick  (tick),
    .clear (state_change),
    .term  (term),
    .done  (done)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      StMainGreen:    if (tick && done && req_q) state_d = StMainYellow;
      StMainYellow:   if (tick && done) state_d = StAllredToSide;
      StAllredToSide: if (tick && done) state_d = StSideGreen;
      StSideGreen:    if (tick && done) state_d = StSideYellow;
      StSideYellow:   if (tick && done) state_d = StAllredToMain;
      StAllredToMain: if (tick && done) state_d = StMainGreen;
      default:        state_d = StMainGreen;
    endcase
  end

  assign state_change = (state_d != state_q);

  // Sensor is ignored during SIDE_GREEN and on the edge entering it.
  always_comb begin
    req_d = req_q;
    if (state_q != StSideGreen) begin
      if (state_d == StSideGreen) begin
        req_d = 1'b0;
      end else if (side_sensor) begin
        req_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StMainGreen;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
    end
  end

  always_comb begin
    main_light = Red;
    side_light = Red;
    case (state_q)
      StMainGreen:  main_light = Green;
      StMainYellow: main_light = Yellow;
      StSideGreen:  side_light = Green;
      StSideYellow: side_light = Yellow;
      default: ;
    endcase
  end

  assign req_pending = req_q;

endmodule

// File: tb/tb_tick_traffic_controller.sv
// Bench for tick_traffic_controller: directed scenarios plus random ticks and
// sensor traffic, compared each cycle against an elapsed-ticks phase model.
module tb_tick_traffic_controller;

  localparam int GREEN = 8;
  localparam int DUR [6] = '{8, 2, 1, 4, 2, 1};
  localparam logic [1:0] MAIN_EXP [6] = '{2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [1:0] SIDE_EXP [6] = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00};

  logic       clk;
  logic       reset;
  logic       tick;
  logic       side_sensor;
  logic [1:0] main_light;
  logic [1:0] side_light;
  logic       req_pending;

  int checks = 0;
  int errors = 0;

  // Model: phase index 0..5 in listed order, ticks elapsed in phase, latch.
  int m_phase, m_ticks, m_phase_n, m_ticks_n;
  bit m_req, m_req_n;

  tick_traffic_controller dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .side_sensor (side_sensor),
    .main_light  (main_light),
    .side_light  (side_light),
    .req_pending (req_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    m_phase_n = m_phase;
    m_ticks_n = m_ticks;
    m_req_n   = m_req;
    if (tick) begin
      if ((m_phase == 0 && m_ticks + 1 >= GREEN && m_req) ||
          (m_phase != 0 && m_ticks + 1 == DUR[m_phase])) begin
        m_phase_n = (m_phase + 1) % 6;
        m_ticks_n = 0;
      end else begin
        m_ticks_n = m_ticks + 1;
      end
    end
    if (m_phase != 3) begin
      if (m_phase_n == 3) m_req_n = 1'b0;
      else if (side_sensor) m_req_n = 1'b1;
    end
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_phase <= 0;
      m_ticks <= 0;
      m_req   <= 1'b0;
    end else begin
      m_phase <= m_phase_n;
      m_ticks <= m_ticks_n;
      m_req   <= m_req_n;
    end
  end

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check_eq("main_light", {6'b0, main_light}, {6'b0, MAIN_EXP[m_phase]});
    check_eq("side_light", {6'b0, side_light}, {6'b0, SIDE_EXP[m_phase]});
    check_eq("req_pending", {7'b0, req_pending}, {7'b0, m_req});
    check_eq("safety", {7'b0, (main_light != 2'b00) && (side_light != 2'b00)}, 8'd0);
  endtask

  task automatic cycle(input logic t, input logic s);
    @(negedge clk);
    check_outputs();
    tick        = t;
    side_sensor = s;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset       = 1'b0;
    tick        = 1'b0;
    side_sensor = 1'b0;
    #1;
    check_eq("rst_main", {6'b0, main_light}, 8'h02);
    check_eq("rst_side", {6'b0, side_light}, 8'h00);
    check_eq("rst_req", {7'b0, req_pending}, 8'h00);
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  logic [1:0] prev_main;
  logic       last_tick;
  int         green_cnt;
  bit         green_valid;
  int         k;

  initial begin
    reset       = 1'b0;
    tick        = 1'b0;
    side_sensor = 1'b0;
    do_reset();

    // Idle: 30 ticks, no requests.
    for (int i = 0; i < 90; i++) cycle(i % 3 == 2, 1'b0);

    // Early request: minimum green must still run its full 8 ticks.
    do_reset();
    for (int i = 0; i < 150; i++) cycle(i % 3 == 2, i == 4);

    // Late request after minimum expired: yellow on the next tick edge.
    for (int i = 0; i < 60; i++) cycle(i % 3 == 2, 1'b0);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    check_eq("late_req_yellow", {6'b0, main_light}, 8'h01);
    for (int i = 0; i < 80; i++) cycle(i % 3 == 2, 1'b0);

    // No ticks: everything frozen except the request latch.
    for (int i = 0; i < 50; i++) cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    check_eq("frozen_req", {7'b0, req_pending}, 8'h01);
    check_eq("frozen_main", {6'b0, main_light}, 8'h02);

    // Asynchronous reset in the middle of SIDE_GREEN.
    k = 0;
    while (m_phase != 3 && k < 200) begin
      cycle(k % 3 == 2, 1'b1);
      k++;
    end
    if (m_phase != 3) begin
      check_eq("reach_side_green", 8'd0, 8'd1);
    end else begin
      @(posedge clk);
      #2;
      reset       = 1'b0;
      tick        = 1'b0;
      side_sensor = 1'b0;
      #1;
      check_eq("async_rst_main", {6'b0, main_light}, 8'h02);
      check_eq("async_rst_side", {6'b0, side_light}, 8'h00);
      check_eq("async_rst_req", {7'b0, req_pending}, 8'h00);
      repeat (2) @(negedge clk);
      reset = 1'b1;
    end

    // Continuous demand: each full main green lasts exactly GREEN ticks.
    prev_main   = 2'b10;
    last_tick   = 1'b0;
    green_cnt   = 0;
    green_valid = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      check_outputs();
      if (prev_main != 2'b10 && main_light == 2'b10) begin
        green_cnt   = 0;
        green_valid = 1'b1;
      end else if (prev_main == 2'b10 && last_tick) begin
        green_cnt++;
      end
      if (prev_main == 2'b10 && main_light == 2'b01) begin
        if (green_valid) check_eq("green_len", 8'(green_cnt), 8'(GREEN));
        green_cnt = 0;
      end
      prev_main   = main_light;
      last_tick   = (i % 3 == 2);
      tick        = last_tick;
      side_sensor = 1'b1;
    end

    // Random ticks and sparse sensor activity.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0);
    end

    cycle(1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
